// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, parameter range checks and in-flight tag type for the FIFO read adapter
package fifo_pkg;

  localparam int M_LEVEL_W = 3;

  typedef struct packed {
    logic live;
    logic discard;
  } infl_tag_t;

  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic bit rd_latency_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic bit buf_depth_ok(input int depth, input int lat);
    return (depth >= lat + 1) && (depth <= 4);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// rtl/fifo_rd_stream_adapter_if.sv - FIFO read port plus first-word-fall-through output stream
interface fifo_rd_stream_adapter_if #(
  parameter int c_DATA_WIDTH = 32
);
  import fifo_pkg::*;

  logic                    fifo_rd_empty;
  logic [c_DATA_WIDTH-1:0] fifo_rd_data;
  logic                    fifo_rd_en;
  logic                    fifo_rd_oce;
  logic                    m_valid;
  logic [c_DATA_WIDTH-1:0] m_data;
  logic                    m_ready;
  logic [M_LEVEL_W-1:0]    m_level;

  // master is the adapter itself: it drains the FIFO and sources the stream
  modport master (
    input  fifo_rd_empty, fifo_rd_data, m_ready,
    output fifo_rd_en, fifo_rd_oce, m_valid, m_data, m_level
  );

  modport slave (
    output fifo_rd_empty, fifo_rd_data, m_ready,
    input  fifo_rd_en, fifo_rd_oce, m_valid, m_data, m_level
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// rtl/fifo_skid_buf.sv - circular register buffer with push/pop/flush and occupancy count
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int c_DATA_WIDTH = 32,
  parameter int c_BUF_DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic [c_DATA_WIDTH-1:0] push_data,
  input  logic                    pop,
  output logic [c_DATA_WIDTH-1:0] head_data,
  output logic [M_LEVEL_W-1:0]    occ
);

  localparam int PTR_W = clog2(c_BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(c_BUF_DEPTH - 1);

  logic [c_DATA_WIDTH-1:0] mem [c_BUF_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;

  // depth need not be a power of two, so wrap explicitly
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < c_BUF_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + M_LEVEL_W'(push) - M_LEVEL_W'(pop);
    end
  end

  assign head_data = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && (occ == M_LEVEL_W'(c_BUF_DEPTH))));

  a_occ_range: assert property (@(posedge clk) disable iff (!rst_n)
    occ <= M_LEVEL_W'(c_BUF_DEPTH));

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// rtl/fifo_rd_stream_adapter.sv - credit-checked FIFO reader that re-presents data as a valid/ready stream
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int c_DATA_WIDTH = 32,
  parameter int c_RD_LATENCY = 1,
  parameter int c_BUF_DEPTH  = c_RD_LATENCY + 1
) (
  input logic                      rd_clk,
  input logic                      rd_rst_n,
  input logic                      flush,
  fifo_rd_stream_adapter_if.master bus
);

  if (!rd_latency_ok(c_RD_LATENCY)) begin : g_bad_latency
    $error("c_RD_LATENCY must be 1 or 2");
  end
  if (!buf_depth_ok(c_BUF_DEPTH, c_RD_LATENCY)) begin : g_bad_depth
    $error("c_BUF_DEPTH must lie in c_RD_LATENCY+1 .. 4");
  end

  infl_tag_t            infl [c_RD_LATENCY];
  logic [M_LEVEL_W-1:0] occ;
  logic [1:0]           infl_live;
  logic [3:0]           credit_used;
  logic                 pop;
  logic                 push;
  logic                 rd_en;

  assign pop = (occ != '0) && bus.m_ready;

  always_comb begin
    infl_live = '0;
    for (int i = 0; i < c_RD_LATENCY; i++)
      infl_live = infl_live + 2'(infl[i].live & ~infl[i].discard);
  end

  // a pop this cycle frees an entry in time for a read issued now
  assign credit_used = 4'(occ) + 4'(infl_live) - 4'(pop);
  assign rd_en       = rd_rst_n & ~bus.fifo_rd_empty & ~flush &
                       (credit_used < 4'(c_BUF_DEPTH));

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < c_RD_LATENCY; i++) infl[i] <= '0;
    end else begin
      infl[0] <= '{live: rd_en, discard: 1'b0};
      for (int i = 1; i < c_RD_LATENCY; i++)
        infl[i] <= '{live: infl[i-1].live, discard: infl[i-1].discard | flush};
    end
  end

  // a return landing in the flush cycle itself is dropped as well
  assign push = infl[c_RD_LATENCY-1].live & ~infl[c_RD_LATENCY-1].discard & ~flush;

  fifo_skid_buf #(
    .c_DATA_WIDTH(c_DATA_WIDTH),
    .c_BUF_DEPTH (c_BUF_DEPTH)
  ) u_skid_buf (
    .clk      (rd_clk),
    .rst_n    (rd_rst_n),
    .flush    (flush),
    .push     (push),
    .push_data(bus.fifo_rd_data),
    .pop      (pop),
    .head_data(bus.m_data),
    .occ      (occ)
  );

  assign bus.fifo_rd_en  = rd_en;
  assign bus.fifo_rd_oce = 1'b1;
  assign bus.m_valid     = (occ != '0);
  assign bus.m_level     = occ;

endmodule

// File: doc/fifo_rd_stream_adapter.md
Name: fifo_rd_stream_adapter

Overview:
- Read-side companion to the async FIFO wrapper, in the rd_clk domain.
- Drives the FIFO's rd_en from rd_empty and captures rd_data after the fixed RAM read latency.
- Re-presents the data as a first-word-fall-through valid/ready stream for downstream logic such as the DSP/display pipeline.
- A small credit-checked skid buffer guarantees no word is lost under backpressure and sustains 1 word/cycle.

Parameters:
- c_DATA_WIDTH, 32, width of FIFO rd_data and m_data.
- c_RD_LATENCY, 1, rd_clk cycles from rd_en high to valid rd_data. Legal 1 or 2: 1 = no output register, 2 = output register with rd_oce held high.
- c_BUF_DEPTH, c_RD_LATENCY+1, skid-buffer entries. Legal range c_RD_LATENCY+1 to 4.

Ports:
- rd_clk, input, 1, read-domain clock.
- rd_rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous discard of buffered and in-flight words.
- fifo_rd_empty, input, 1, FIFO empty flag.
- fifo_rd_data, input, c_DATA_WIDTH, FIFO read data.
- fifo_rd_en, output, 1, FIFO read enable.
- fifo_rd_oce, output, 1, FIFO output-register enable.
- m_valid, output, 1, stream word valid.
- m_data, output, c_DATA_WIDTH, stream word.
- m_ready, input, 1, downstream accept.
- m_level, output, 3, current buffer occupancy.

Behaviour:
- Reset (rd_rst_n low, asynchronous):
  - fifo_rd_en=0, m_valid=0, m_data=0, m_level=0.
  - In-flight pipeline and discard tags cleared.
  - fifo_rd_oce=1 always, including during reset.
- State:
  - occ (0..c_BUF_DEPTH).
  - In-flight shift register infl[c_RD_LATENCY-1:0]; each bit carries a request tag plus a discard flag.
  - Circular buffer with wr_ptr and rd_ptr, mod c_BUF_DEPTH.
- Pop: pop = m_valid & m_ready. m_valid = (occ!=0). m_data = buf[rd_ptr], driven from registered storage.
- Issue: fifo_rd_en = !fifo_rd_empty & !flush & (occ + popcount(live infl) - pop < c_BUF_DEPTH).
  - Combinational path from m_ready to fifo_rd_en is permitted.
  - The credit check means occ can never exceed c_BUF_DEPTH. Overflow is impossible by construction; an assertion checks it.
- Return: a request issued at cycle t returns at t+c_RD_LATENCY. If its tag is live and not discarded, fifo_rd_data is written to buf[wr_ptr] and wr_ptr increments.
- Occupancy update: occ_next = occ + push - pop. Simultaneous push and pop leaves occ unchanged. Pointers wrap modulo c_BUF_DEPTH.
- Latency: FIFO non-empty to first m_valid = c_RD_LATENCY+1 cycles, counted from the cycle fifo_rd_en is sampled high.
- Throughput: with m_ready held high and FIFO non-empty, 1 word per cycle, with no bubbles after the first.
- Backpressure: when m_ready is low, fifo_rd_en deasserts once occ + in-flight reaches c_BUF_DEPTH. Words already in flight land in free entries.
- Empty: FIFO rd_empty high means no read is issued; the buffer drains normally. Reads are never issued while fifo_rd_empty is high, so FIFO underflow cannot occur.
- flush (high for one or more cycles):
  - Same cycle: occ, wr_ptr and rd_ptr go to 0, m_valid is 0 from the next cycle, and fifo_rd_en=0.
  - All live in-flight tags are marked discard, so their returns are dropped.
  - Reads may resume the cycle after flush deasserts.
  - A pop in the flush cycle is still considered accepted by the consumer.
- Order: words are delivered strictly in FIFO order, with no duplication.

Decomposition:
- Shared package fifo_pkg holds:
  - the legal-range checks for c_RD_LATENCY and c_BUF_DEPTH;
  - a clog2 constant function for the pointer width;
  - the M_LEVEL_W=3 constant.
- One sub-module is natural: fifo_skid_buf, the c_BUF_DEPTH-entry register buffer with push/pop/flush and occ.
- The top level holds the credit logic and the in-flight tag pipeline.

Test Plan:
- Reset, then preload 8 words 0x0..0x7 into the FIFO, with c_RD_LATENCY=1 and m_ready=1 → first fifo_rd_en on cycle 1, first m_valid with m_data=0x0 on cycle 3. Then 0x1..0x7 on consecutive cycles; m_level ≤ 2 throughout.
- c_RD_LATENCY=2, 16 words, m_ready toggling 1/0 each cycle → all 16 words delivered in order and none dropped. fifo_rd_en deasserts whenever occ + in-flight = 3; m_level never exceeds 3.
- Hold m_ready=0 with the FIFO full → exactly c_BUF_DEPTH rd_en pulses, then fifo_rd_en stays 0. Release m_ready → the stream resumes with the next sequential value and no gap beyond one cycle.
- FIFO goes empty mid-burst after word 0x4 → fifo_rd_en drops the same cycle rd_empty rises. Buffered words drain, then m_valid=0. A new word 0x9 appears at c_RD_LATENCY+1 cycles after rd_empty falls.
- Assert flush while 2 words are in flight and 1 is buffered → m_valid=0 next cycle and the in-flight returns are discarded. After flush, the stream resumes with the next FIFO word, e.g. 0x6 if 0x3..0x5 were flushed.
- Assert rd_rst_n low mid-stream, asynchronously between edges → m_valid and fifo_rd_en go low immediately and m_level=0. After release, no stale word is emitted.
